// File: rtl/stream_min_max.sv
// Per-frame running minimum/maximum over a valid/ready sample stream.
// Emits one held result per frame of programmable length, unsigned or signed compare.
module stream_min_max #(
   parameter int unsigned INPUT_BIT_WIDTH = 32,
   parameter int unsigned INDEX_BIT_WIDTH = 8,
   parameter bit          SIGNED          = 1'b0
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       Clear,
   input  logic [INDEX_BIT_WIDTH-1:0] FrameLength,
   input  logic                       InValid,
   input  logic [INPUT_BIT_WIDTH-1:0] InData,
   output logic                       InReady,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic [INPUT_BIT_WIDTH-1:0] OutMax,
   output logic [INPUT_BIT_WIDTH-1:0] OutMin,
   output logic [INDEX_BIT_WIDTH-1:0] OutMaxIndex,
   output logic [INDEX_BIT_WIDTH-1:0] OutMinIndex
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                     state;
   logic [INDEX_BIT_WIDTH-1:0] count;
   logic [INDEX_BIT_WIDTH-1:0] len;
   logic [INPUT_BIT_WIDTH-1:0] run_max;
   logic [INPUT_BIT_WIDTH-1:0] run_min;
   logic [INDEX_BIT_WIDTH-1:0] max_idx;
   logic [INDEX_BIT_WIDTH-1:0] min_idx;

   logic                       accept;
   logic                       gt;
   logic                       lt;
   logic                       last;
   logic [INDEX_BIT_WIDTH-1:0] len_eff;
   logic [INPUT_BIT_WIDTH-1:0] nxt_max;
   logic [INPUT_BIT_WIDTH-1:0] nxt_min;
   logic [INDEX_BIT_WIDTH-1:0] nxt_max_idx;
   logic [INDEX_BIT_WIDTH-1:0] nxt_min_idx;

   function automatic logic greater(input logic [INPUT_BIT_WIDTH-1:0] a,
                                    input logic [INPUT_BIT_WIDTH-1:0] b);
      if (SIGNED) return $signed(a) > $signed(b);
      else        return a > b;
   endfunction

   // Ready depends only on state and reset, never on the input side.
   assign InReady = (state != HOLD) && !Reset;

   always_comb begin
      accept      = InValid && InReady;
      gt          = greater(InData, run_max);
      lt          = greater(run_min, InData);
      last        = (count == INDEX_BIT_WIDTH'(len - INDEX_BIT_WIDTH'(1)));
      len_eff     = (FrameLength == '0) ? INDEX_BIT_WIDTH'(1) : FrameLength;
      nxt_max     = gt ? InData : run_max;
      nxt_min     = lt ? InData : run_min;
      nxt_max_idx = gt ? count : max_idx;
      nxt_min_idx = lt ? count : min_idx;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         count       <= '0;
         len         <= '0;
         run_max     <= '0;
         run_min     <= '0;
         max_idx     <= '0;
         min_idx     <= '0;
         OutValid    <= 1'b0;
         OutMax      <= '0;
         OutMin      <= '0;
         OutMaxIndex <= '0;
         OutMinIndex <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!Clear && accept) begin
                  len     <= len_eff;
                  run_max <= InData;
                  run_min <= InData;
                  max_idx <= '0;
                  min_idx <= '0;
                  count   <= INDEX_BIT_WIDTH'(1);
                  if (len_eff == INDEX_BIT_WIDTH'(1)) begin
                     state       <= HOLD;
                     OutValid    <= 1'b1;
                     OutMax      <= InData;
                     OutMin      <= InData;
                     OutMaxIndex <= '0;
                     OutMinIndex <= '0;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (Clear) begin
                  state <= IDLE;
                  count <= '0;
               end else if (accept) begin
                  run_max <= nxt_max;
                  run_min <= nxt_min;
                  max_idx <= nxt_max_idx;
                  min_idx <= nxt_min_idx;
                  count   <= INDEX_BIT_WIDTH'(count + INDEX_BIT_WIDTH'(1));
                  if (last) begin
                     state       <= HOLD;
                     OutValid    <= 1'b1;
                     OutMax      <= nxt_max;
                     OutMin      <= nxt_min;
                     OutMaxIndex <= nxt_max_idx;
                     OutMinIndex <= nxt_min_idx;
                  end
               end
            end
            HOLD: begin
               // Clear is deliberately ignored here; only the consumer releases the result.
               if (OutReady) begin
                  state    <= IDLE;
                  OutValid <= 1'b0;
                  count    <= '0;
               end
            end
            default: begin
               state    <= IDLE;
               OutValid <= 1'b0;
               count    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_min_max.sv
// Directed bench for stream_min_max: one unsigned and one signed instance share the stimulus.
module tb_stream_min_max;

   localparam int unsigned W  = 32;
   localparam int unsigned IW = 8;

   logic          clk;
   logic          reset;
   logic          clear;
   logic [IW-1:0] frame_length;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          out_ready;

   logic          in_ready_u, out_valid_u, in_ready_s, out_valid_s;
   logic [W-1:0]  out_max_u, out_min_u, out_max_s, out_min_s;
   logic [IW-1:0] max_idx_u, min_idx_u, max_idx_s, min_idx_s;

   int checks = 0;
   int errors = 0;

   stream_min_max #(.INPUT_BIT_WIDTH(W), .INDEX_BIT_WIDTH(IW), .SIGNED(1'b0)) u_dut (
      .Clk(clk), .Reset(reset), .Clear(clear), .FrameLength(frame_length),
      .InValid(in_valid), .InData(in_data), .InReady(in_ready_u),
      .OutValid(out_valid_u), .OutReady(out_ready),
      .OutMax(out_max_u), .OutMin(out_min_u),
      .OutMaxIndex(max_idx_u), .OutMinIndex(min_idx_u)
   );

   stream_min_max #(.INPUT_BIT_WIDTH(W), .INDEX_BIT_WIDTH(IW), .SIGNED(1'b1)) s_dut (
      .Clk(clk), .Reset(reset), .Clear(clear), .FrameLength(frame_length),
      .InValid(in_valid), .InData(in_data), .InReady(in_ready_s),
      .OutValid(out_valid_s), .OutReady(out_ready),
      .OutMax(out_max_s), .OutMin(out_min_s),
      .OutMaxIndex(max_idx_s), .OutMinIndex(min_idx_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic ack();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic check_u(input string tag, input logic [W-1:0] mx, input logic [IW-1:0] mxi,
                          input logic [W-1:0] mn, input logic [IW-1:0] mni);
      check({tag, "_valid"}, 64'(out_valid_u), 64'd1);
      check({tag, "_max"},   64'(out_max_u),   64'(mx));
      check({tag, "_maxi"},  64'(max_idx_u),   64'(mxi));
      check({tag, "_min"},   64'(out_min_u),   64'(mn));
      check({tag, "_mini"},  64'(min_idx_u),   64'(mni));
   endtask

   initial begin
      reset        = 1'b1;
      clear        = 1'b0;
      frame_length = 8'd1;
      in_valid     = 1'b1;
      in_data      = 32'd55;
      out_ready    = 1'b0;

      // Reset held two cycles with a live sample presented.
      step();
      step();
      check("rst_ready", 64'(in_ready_u), 64'd0);
      check("rst_valid", 64'(out_valid_u), 64'd0);
      check("rst_max",   64'(out_max_u), 64'd0);
      check("rst_min",   64'(out_min_u), 64'd0);
      check("rst_idx",   64'({max_idx_u, min_idx_u}), 64'd0);
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rel_ready", 64'(in_ready_u), 64'd1);

      // Unsigned frame with latency checks.
      frame_length = 8'd4;
      send(32'd12);
      send(32'd100);
      send(32'd0);
      check("f1_early", 64'(out_valid_u), 64'd0);
      send(32'd1024);
      check_u("f1", 32'd1024, 8'd3, 32'd0, 8'd2);
      check("f1_hold_ready", 64'(in_ready_u), 64'd0);
      ack();
      check("f1_drop", 64'(out_valid_u), 64'd0);
      check("f1_keep", 64'(out_max_u), 64'd1024);

      // Ties keep the earliest index.
      frame_length = 8'd3;
      send(32'd7);
      send(32'd7);
      send(32'd7);
      check_u("tie", 32'd7, 8'd0, 32'd7, 8'd0);
      ack();

      // Length 1 and length 0 both complete after a single sample.
      frame_length = 8'd1;
      send(32'd99);
      check_u("len1", 32'd99, 8'd0, 32'd99, 8'd0);
      ack();
      frame_length = 8'd0;
      send(32'd5);
      check_u("len0", 32'd5, 8'd0, 32'd5, 8'd0);
      ack();

      // Signed versus unsigned interpretation of the same frame.
      frame_length = 8'd3;
      send(32'd5);
      send(32'hFFFF_FFFE);
      send(32'd3);
      check_u("uns", 32'hFFFF_FFFE, 8'd1, 32'd3, 8'd2);
      check("sgn_valid", 64'(out_valid_s), 64'd1);
      check("sgn_max",   64'(out_max_s), 64'd5);
      check("sgn_maxi",  64'(max_idx_s), 64'd0);
      check("sgn_min",   64'(out_min_s), 64'hFFFF_FFFE);
      check("sgn_mini",  64'(min_idx_s), 64'd1);
      ack();

      // Backpressure: samples presented during HOLD are ignored.
      frame_length = 8'd2;
      send(32'd10);
      send(32'd20);
      in_valid     = 1'b1;
      in_data      = 32'd777;
      frame_length = 8'd1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_ready", 64'(in_ready_u), 64'd0);
         check("bp_valid", 64'(out_valid_u), 64'd1);
         check("bp_max",   64'(out_max_u), 64'd20);
      end
      in_valid = 1'b0;
      ack();
      check("bp_drop", 64'(out_valid_u), 64'd0);

      // Consumer ready before the result: accepted on its first valid cycle.
      frame_length = 8'd2;
      out_ready    = 1'b1;
      send(32'd1);
      send(32'd2);
      check_u("early_rdy", 32'd2, 8'd1, 32'd1, 8'd0);
      step();
      check("early_rdy_drop", 64'(out_valid_u), 64'd0);
      out_ready = 1'b0;

      // Clear mid-frame drops the partial frame and the same-cycle sample.
      frame_length = 8'd4;
      send(32'd50);
      send(32'd60);
      clear = 1'b1;
      send(32'd200);
      clear = 1'b0;
      check("clr_valid", 64'(out_valid_u), 64'd0);
      send(32'd1);
      send(32'd2);
      send(32'd3);
      check("clr_early", 64'(out_valid_u), 64'd0);
      send(32'd4);
      check_u("clr", 32'd4, 8'd3, 32'd1, 8'd0);

      // Clear in HOLD is ignored.
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_u("clr_hold", 32'd4, 8'd3, 32'd1, 8'd0);
      ack();

      // FrameLength changes after the first sample do not affect the frame.
      frame_length = 8'd3;
      send(32'd9);
      frame_length = 8'd1;
      send(32'd4);
      check("fl_early", 64'(out_valid_u), 64'd0);
      send(32'd6);
      check_u("fl", 32'd9, 8'd0, 32'd4, 8'd1);
      ack();

      // Reset during HOLD.
      frame_length = 8'd1;
      send(32'd3);
      check("rh_valid_pre", 64'(out_valid_u), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rh_valid", 64'(out_valid_u), 64'd0);
      check("rh_max",   64'(out_max_u), 64'd0);

      // Reset mid-frame, then an intact frame.
      frame_length = 8'd3;
      send(32'd8);
      reset = 1'b1;
      step();
      reset = 1'b0;
      frame_length = 8'd2;
      send(32'd5);
      check("rm_early", 64'(out_valid_u), 64'd0);
      send(32'd6);
      check_u("rm", 32'd6, 8'd1, 32'd5, 8'd0);
      ack();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
